// File: rtl/accel_pkg.sv
// Shared types and defaults for the adder-tree feeder and neighbouring accelerator blocks.
package accel_pkg;
  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_INPUT_NUM = 8;

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} feeder_state_e;

  typedef logic [DEFAULT_INPUT_NUM-1:0][DEFAULT_WIDTH-1:0] lane_vec_t;

  // One delay-line entry: an issued vector and whether it closes its group.
  typedef struct packed {
    logic valid;
    logic last;
  } dl_entry_t;
endpackage

// File: rtl/adder_tree_feeder_if.sv
// Operand stream in and result stream out of the adder-tree feeder.
interface adder_tree_feeder_if #(
  parameter int WIDTH = accel_pkg::DEFAULT_WIDTH
);
  // in_*: a beat transfers on a rising edge where in_valid && in_ready; in_data/in_last
  // are held stable while in_valid is high. out_*: no ready, every out_valid pulse is consumed.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that tracks sideband through a fixed-latency pipeline.
module valid_delay_line #(
  parameter int DEPTH = 3,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [DEPTH-1:0][W-1:0] sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/adder_tree_feeder.sv
// Packs a scalar operand stream into lane vectors for adder_tree and re-times its
// result into a tagged, group-delimited output stream.
module adder_tree_feeder
  import accel_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int INPUT_NUM = DEFAULT_INPUT_NUM,
  parameter int STAGE_NUM = $clog2(INPUT_NUM),
  parameter int TREE_LAT  = STAGE_NUM
) (
  input  logic                            clk,
  input  logic                            rst,
  adder_tree_feeder_if.slave              bus,
  output logic [INPUT_NUM-1:0][WIDTH-1:0] tree_data,
  input  logic [WIDTH-1:0]                tree_res,
  output feeder_state_e                   dbg_state
);
  localparam int IDX_W = $clog2(INPUT_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_NUM - 1);

  feeder_state_e                   state;
  logic                            in_ready_q;
  logic [INPUT_NUM-1:0][WIDTH-1:0] lane_buf;
  logic [INPUT_NUM-1:0][WIDTH-1:0] merged;
  logic [IDX_W-1:0]                idx;
  logic                            accept;
  logic                            complete;
  dl_entry_t                       dl_in;
  dl_entry_t                       dl_out;
  logic                            out_valid_q;
  logic                            out_last_q;
  logic [WIDTH-1:0]                out_data_q;

  assign accept   = bus.in_valid && in_ready_q;
  assign complete = accept && ((idx == LAST_IDX) || bus.in_last);

  // Current beat lands in lane idx; everything above it is padding.
  always_comb begin
    merged = lane_buf;
    for (int i = 0; i < INPUT_NUM; i++) begin
      if (i == int'(idx)) begin
        merged[i] = bus.in_data;
      end else if (i > int'(idx)) begin
        merged[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_buf  <= '0;
      idx       <= '0;
      tree_data <= '0;
    end else begin
      tree_data <= '0;
      if (complete) begin
        tree_data <= merged;
        lane_buf  <= '0;
        idx       <= '0;
      end else if (accept) begin
        lane_buf[idx] <= bus.in_data;
        idx           <= idx + IDX_W'(1);
      end
    end
  end

  // Only one group is ever in the tree: input stays closed until its last result leaves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FILL;
      in_ready_q <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept && bus.in_last) begin
            state      <= DRAIN;
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_valid_q && out_last_q) begin
            state      <= FILL;
            in_ready_q <= 1'b1;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          state      <= FILL;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign dl_in.valid = complete;
  assign dl_in.last  = complete && bus.in_last;

  valid_delay_line #(
    .DEPTH (TREE_LAT),
    .W     ($bits(dl_entry_t))
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (dl_in),
    .dout (dl_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= dl_out.valid;
      out_last_q  <= dl_out.valid && dl_out.last;
      if (dl_out.valid) begin
        out_data_q <= tree_res;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_adder_tree_feeder.sv
// Bench for adder_tree_feeder with a behavioural adder_tree and a result scoreboard.
module tb_adder_tree_feeder;
  import accel_pkg::*;

  localparam int W = 32;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adder_tree_feeder_if #(.WIDTH(W)) bus ();
  lane_vec_t     tree_data;
  logic [W-1:0]  tree_res;
  feeder_state_e dbg_state;

  adder_tree_feeder #(.WIDTH(W), .INPUT_NUM(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .tree_data (tree_data),
    .tree_res  (tree_res),
    .dbg_state (dbg_state)
  );

  // Reference tree: sum visible on tree_res two cycles after tree_data; never reset.
  logic [W-1:0] s1 = '0;
  logic [W-1:0] s2 = '0;

  function automatic logic [W-1:0] lane_sum(input lane_vec_t v);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + v[i];
    return s;
  endfunction

  always @(posedge clk) begin
    s1 <= lane_sum(tree_data);
    s2 <= s1;
  end
  assign tree_res = s2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int stalls = 0;
  logic [W:0]   exp_q[$];
  int           out_cyc[$];
  logic [W-1:0] acc_sum = '0;
  int           acc_cnt = 0;
  logic [W:0]   mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard side: every out_valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check_eq("spurious_out_valid", 256'(1), 256'(0));
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("out_data", 256'(bus.out_data), 256'(mon_exp[W-1:0]));
        check_eq("out_last", 256'(bus.out_last), 256'(mon_exp[W]));
      end
    end
  end

  task automatic send_beat(input logic [W-1:0] d, input logic l);
    int  guard;
    bit  ok;
    guard = 0;
    ok    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!ok) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        stalls++;
        guard++;
        @(posedge clk);
        #1;
        if (guard > 200) begin
          check_eq("accept_timeout", 256'(0), 256'(1));
          bus.in_valid = 1'b0;
          return;
        end
      end
    end
    acc_sum = acc_sum + d;
    acc_cnt++;
    if (acc_cnt == N || l) begin
      exp_q.push_back({l, acc_sum});
      acc_sum = '0;
      acc_cnt = 0;
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    bus.in_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.in_ready === 1'b1) break;
      guard++;
      if (guard > 100) begin
        check_eq("drain_timeout", 256'(exp_q.size()), 256'(0));
        exp_q.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check_eq({tag, "_in_ready"},  256'(bus.in_ready),  256'(0));
    check_eq({tag, "_out_valid"}, 256'(bus.out_valid), 256'(0));
    check_eq({tag, "_out_last"},  256'(bus.out_last),  256'(0));
    check_eq({tag, "_out_data"},  256'(bus.out_data),  256'(0));
    check_eq({tag, "_tree_data"}, 256'(tree_data),     256'(0));
    check_eq({tag, "_state"},     256'(dbg_state),     256'(FILL));
  endtask

  lane_vec_t exp_vec;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    // Reset and release
    repeat (2) @(posedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("ready_after_reset", 256'(bus.in_ready), 256'(1));
    @(posedge clk);
    #1;

    // 1: beats 1..8 with exact latency and in_ready timing
    for (int i = 1; i <= N; i++) send_beat(W'(i), i == N);
    bus.in_valid = 1'b0;
    for (int i = 0; i < N; i++) exp_vec[i] = W'(i + 1);
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c == 0) check_eq("t1_tree_data", 256'(tree_data), 256'(exp_vec));
      if (c == 1) check_eq("t1_tree_data_idle", 256'(tree_data), 256'(0));
      check_eq("t1_in_ready", 256'(bus.in_ready), 256'(c == 4));
      check_eq("t1_out_valid", 256'(bus.out_valid), 256'(c == 3));
    end
    @(posedge clk);
    #1;
    wait_drain();

    // 2: short group is zero padded
    send_beat(32'd5, 1'b0);
    send_beat(32'd6, 1'b0);
    send_beat(32'd7, 1'b1);
    bus.in_valid = 1'b0;
    exp_vec = '0;
    exp_vec[0] = 32'd5;
    exp_vec[1] = 32'd6;
    exp_vec[2] = 32'd7;
    @(negedge clk);
    check_eq("t2_tree_data", 256'(tree_data), 256'(exp_vec));
    wait_drain();

    // 3: two vectors without bubbles
    stalls = 0;
    out_cyc.delete();
    for (int i = 1; i <= 2 * N; i++) send_beat(W'(i), i == 2 * N);
    check_eq("t3_no_stall", 256'(stalls), 256'(0));
    wait_drain();
    check_eq("t3_result_count", 256'(out_cyc.size()), 256'(2));
    if (out_cyc.size() == 2)
      check_eq("t3_result_spacing", 256'(out_cyc[1] - out_cyc[0]), 256'(8));

    // 4: gapped input valid
    out_cyc.delete();
    for (int i = 1; i <= N; i++) begin
      send_beat(W'(i), i == N);
      if (i < N) idle($urandom_range(1, 2));
    end
    wait_drain();
    check_eq("t4_result_count", 256'(out_cyc.size()), 256'(1));

    // 5: reset while the group is in the tree
    out_cyc.delete();
    for (int i = 1; i <= N; i++) send_beat(W'(i), i == N);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    acc_sum = '0;
    acc_cnt = 0;
    check_reset_state("midreset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("t5_ready_after_reset", 256'(bus.in_ready), 256'(1));
    repeat (8) @(posedge clk);
    #1;
    check_eq("t5_no_output", 256'(out_cyc.size()), 256'(0));
    send_beat(32'd2, 1'b0);
    send_beat(32'd2, 1'b1);
    wait_drain();

    // 6: wraparound, plus random groups
    for (int i = 1; i <= N; i++) send_beat(32'hFFFF_FFFF, i == N);
    wait_drain();
    for (int g = 0; g < 4; g++) begin
      int len;
      len = $urandom_range(1, 2 * N + 3);
      for (int i = 1; i <= len; i++) send_beat(W'($urandom), i == len);
      wait_drain();
    end
    send_beat(32'd9, 1'b1);
    wait_drain();

    check_eq("final_queue_empty", 256'(exp_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
